// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_arbiter
//  Description : Round-robin arbiter owning the select of an N-way Mux that
//                shares one datapath resource among N requesters. Issues a
//                registered one-hot grant, the binary select index and a busy
//                flag. A programmable hold limit forces rotation so one
//                requester cannot starve the others.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int N        = 16,   // number of requesters, must equal 2**SW
    parameter int SW       = 4,    // select width, matches Mux signWidth
    parameter int MAX_HOLD = 8     // grant cycles before forced rotation, 0 = off
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] sel,
    output logic          busy
);

    // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
    localparam int             c_HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = (MAX_HOLD > 0) ? c_HW'(MAX_HOLD - 1) : '0;
    localparam bit             c_HOLD_EN   = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   owner_q, owner_d;
    logic [SW-1:0]   ptr_q,   ptr_d;
    logic [c_HW-1:0] hold_q,  hold_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [SW-1:0]   sel_q,   sel_d;
    logic            busy_q,  busy_d;

    logic [SW-1:0]   owner_nxt;   // index just after the current owner (wraps)
    logic [N-1:0]    others;      // requests from everyone except the owner

    // First set bit of mask scanning start, start+1, ... with mod-N wrap.
    // SW-bit index arithmetic provides the wrap for free since N == 2**SW.
    function automatic logic [SW-1:0] pick(input logic [N-1:0]  mask,
                                           input logic [SW-1:0] start);
        logic [SW-1:0] idx;
        logic [SW-1:0] res;
        logic          found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = start + SW'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign owner_nxt = owner_q + SW'(1);
    assign others    = req & ~gnt_q;

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = pick(req, ptr_q);
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    // Owner released: hand over directly, or fall back to idle.
                    ptr_d  = owner_nxt;
                    hold_d = '0;
                    if (|req) begin
                        owner_d = pick(req, owner_nxt);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (c_HOLD_EN && (hold_q == c_HOLD_LAST)) begin
                    // Hold limit reached: rotate only if someone else is waiting.
                    hold_d = '0;
                    if (|others) begin
                        owner_d = pick(others, owner_nxt);
                        ptr_d   = owner_nxt;
                    end
                end else if (c_HOLD_EN) begin
                    hold_d = hold_q + c_HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gnt_d  = (state_d == ST_GRANT) ? (N'(1) << owner_d) : '0;
        sel_d  = (state_d == ST_GRANT) ? owner_d : '0;
        busy_d = (state_d == ST_GRANT);
    end

    // Arbitration FSM state and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule
`default_nettype wire
